// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer
//   Destination-domain command sequencer for the UART-ALU system. Consumes
//   synchronized RX bytes (sync_bus qualified by enable_pulse_d), parses them
//   into command frames, drives the register file and ALU, and returns read or
//   ALU results byte-wise to the TX path over a valid/busy handshake.
//
//   Commands (first byte of a frame):
//     0xAA addr data      register-file write
//     0xBB addr           register-file read, one response byte
//     0xCC opA opB fun    write opA@0, opB@1, run ALU, two response bytes
//     0xDD fun            run ALU on current operands, two response bytes
//
// Ports
//   dest_clk, dest_rst           clock (rising edge), async active-low reset
//   sync_bus, enable_pulse_d     synchronized RX byte and its one-cycle strobe
//   rf_wr_en, rf_rd_en           register-file write / read strobes
//   rf_addr, rf_wr_data          register-file address / write data
//   rf_rd_data, rf_rd_valid      register-file read response
//   alu_en, alu_fun              ALU start strobe and function code
//   alu_out, alu_out_valid       ALU result
//   clk_gate_en                  ALU clock-gate enable
//   tx_data, tx_valid, tx_busy   response byte handshake to TX path
//   frame_err                    one-cycle pulse: illegal command or overrun byte
module rx_cmd_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     dest_clk,
    input  logic                     dest_rst,
    input  logic [DATA_WIDTH-1:0]    sync_bus,
    input  logic                     enable_pulse_d,
    output logic                     rf_wr_en,
    output logic                     rf_rd_en,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data,
    input  logic                     rf_rd_valid,
    output logic                     alu_en,
    output logic [FUN_WIDTH-1:0]     alu_fun,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    input  logic                     alu_out_valid,
    output logic                     clk_gate_en,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_busy,
    output logic                     frame_err
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN,
        RF_RD, WAIT_RD, ALU_ISSUE, WAIT_ALU, SEND_LO, SEND_HI
    } state_t;

    state_t                   state, state_nxt;
    logic                     is_read;       // current frame is 0xBB: GET_ADDR leads to a read, one TX byte
    logic [ALU_OUT_WIDTH-1:0] result;        // captured read data or ALU result
    logic                     frame_err_nxt;
    logic                     tx_xfer;

    assign tx_xfer = tx_valid && !tx_busy;

    // State register
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt     = state;
        frame_err_nxt = 1'b0;
        rf_rd_en      = 1'b0;
        alu_en        = 1'b0;
        clk_gate_en   = 1'b0;
        case (state)
            IDLE: begin
                if (enable_pulse_d) begin
                    case (sync_bus)
                        CMD_WR, CMD_RD: state_nxt = GET_ADDR;
                        CMD_ALU_OP:     state_nxt = GET_OPA;
                        CMD_ALU_NOP:    state_nxt = GET_FUN;
                        default:        frame_err_nxt = 1'b1;
                    endcase
                end
            end
            GET_ADDR:  if (enable_pulse_d) state_nxt = is_read ? RF_RD : GET_WDATA;
            GET_WDATA: if (enable_pulse_d) state_nxt = IDLE;
            GET_OPA:   if (enable_pulse_d) state_nxt = GET_OPB;
            GET_OPB:   if (enable_pulse_d) state_nxt = GET_FUN;
            GET_FUN: begin
                clk_gate_en = 1'b1;
                if (enable_pulse_d) state_nxt = ALU_ISSUE;
            end
            RF_RD: begin
                rf_rd_en      = 1'b1;
                frame_err_nxt = enable_pulse_d;
                state_nxt     = WAIT_RD;
            end
            WAIT_RD: begin
                frame_err_nxt = enable_pulse_d;
                if (rf_rd_valid) state_nxt = SEND_LO;
            end
            ALU_ISSUE: begin
                alu_en        = 1'b1;
                clk_gate_en   = 1'b1;
                frame_err_nxt = enable_pulse_d;
                state_nxt     = WAIT_ALU;
            end
            WAIT_ALU: begin
                clk_gate_en   = 1'b1;
                frame_err_nxt = enable_pulse_d;
                if (alu_out_valid) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                frame_err_nxt = enable_pulse_d;
                if (tx_xfer) state_nxt = is_read ? IDLE : SEND_HI;
            end
            SEND_HI: begin
                frame_err_nxt = enable_pulse_d;
                if (tx_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            rf_wr_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
            result     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            is_read    <= 1'b0;
        end else begin
            rf_wr_en  <= 1'b0;
            frame_err <= frame_err_nxt;
            case (state)
                IDLE: if (enable_pulse_d) is_read <= (sync_bus == CMD_RD);
                GET_ADDR: if (enable_pulse_d) rf_addr <= sync_bus[ADDR_WIDTH-1:0];
                GET_WDATA: begin
                    if (enable_pulse_d) begin
                        rf_wr_data <= sync_bus;
                        rf_wr_en   <= 1'b1;
                    end
                end
                GET_OPA: begin
                    if (enable_pulse_d) begin
                        rf_addr    <= '0;
                        rf_wr_data <= sync_bus;
                        rf_wr_en   <= 1'b1;
                    end
                end
                GET_OPB: begin
                    if (enable_pulse_d) begin
                        rf_addr    <= ADDR_WIDTH'(1);
                        rf_wr_data <= sync_bus;
                        rf_wr_en   <= 1'b1;
                    end
                end
                GET_FUN: if (enable_pulse_d) alu_fun <= sync_bus[FUN_WIDTH-1:0];
                WAIT_RD: begin
                    if (rf_rd_valid)
                        result <= {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, rf_rd_data};
                end
                WAIT_ALU: if (alu_out_valid) result <= alu_out;
                // Each SEND state spends its first cycle with tx_valid low, which
                // provides the mandatory idle gap between bytes; tx_data is only
                // loaded while tx_valid is low, so it cannot change under a stall.
                SEND_LO, SEND_HI: begin
                    if (tx_valid) begin
                        if (!tx_busy) tx_valid <= 1'b0;
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= (state == SEND_LO) ? result[DATA_WIDTH-1:0]
                                                       : result[DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
module tb_rx_cmd_sequencer;

    logic        dest_clk;
    logic        dest_rst;
    logic [7:0]  sync_bus;
    logic        enable_pulse_d;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        frame_err;

    // responder-driven and stimulus-driven halves of the handshake inputs
    logic        rsp_rd_valid, spur_rd_valid;
    logic        rsp_alu_valid, spur_alu_valid;
    logic [15:0] alu_resp;
    int          alu_lat;

    assign rf_rd_valid   = rsp_rd_valid | spur_rd_valid;
    assign alu_out_valid = rsp_alu_valid | spur_alu_valid;
    assign alu_out       = alu_resp;

    rx_cmd_sequencer dut (
        .dest_clk      (dest_clk),
        .dest_rst      (dest_rst),
        .sync_bus      (sync_bus),
        .enable_pulse_d(enable_pulse_d),
        .rf_wr_en      (rf_wr_en),
        .rf_rd_en      (rf_rd_en),
        .rf_addr       (rf_addr),
        .rf_wr_data    (rf_wr_data),
        .rf_rd_data    (rf_rd_data),
        .rf_rd_valid   (rf_rd_valid),
        .alu_en        (alu_en),
        .alu_fun       (alu_fun),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .clk_gate_en   (clk_gate_en),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_busy       (tx_busy),
        .frame_err     (frame_err)
    );

    initial begin
        dest_clk = 1'b0;
        forever #5 dest_clk = ~dest_clk;
    end

    // Register file and ALU stand-ins: the RF answers a read one cycle after
    // rf_rd_en, the ALU answers alu_lat cycles after alu_en.
    logic [7:0] rf_mem [16];
    initial begin
        logic       c_wr, c_rd, c_alu;
        logic [3:0] c_addr;
        logic [7:0] c_data;
        int         cnt;
        cnt = 0;
        rsp_rd_valid  = 1'b0;
        rsp_alu_valid = 1'b0;
        rf_rd_data    = 8'h00;
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        forever begin
            @(negedge dest_clk);
            c_wr = rf_wr_en; c_rd = rf_rd_en; c_alu = alu_en;
            c_addr = rf_addr; c_data = rf_wr_data;
            @(posedge dest_clk);
            if (c_wr) rf_mem[c_addr] = c_data;
            #1;
            rsp_rd_valid = c_rd;
            if (c_rd) rf_rd_data = rf_mem[c_addr];
            if (c_alu) cnt = alu_lat;
            rsp_alu_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) rsp_alu_valid = 1'b1;
            end
        end
    end

    // Transaction-level model: what each frame must produce
    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [3:0] exp_fun[$];
    logic [7:0] exp_tx[$];
    logic [7:0] model_mem [16];
    int         err_exp, err_seen;
    int         checks, failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge dest_clk); #1;
        sync_bus = b; enable_pulse_d = 1'b1;
        @(posedge dest_clk); #1;
        enable_pulse_d = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge dest_clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size()) != 0 && n < budget) begin
            @(posedge dest_clk);
            n++;
        end
        chk("queues_drained", exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size(), 0);
        cycles(3);
    endtask

    task automatic wait_tx_valid(input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            cycles(1);
            n++;
        end
        chk("tx_valid_timeout", tx_valid, 1);
    endtask

    task automatic push_rd(input logic [3:0] a);
        exp_rd.push_back(a);
        exp_tx.push_back(model_mem[a]);
    endtask

    task automatic push_alu(input logic [3:0] f, input logic [15:0] r);
        exp_fun.push_back(f);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
    endtask

    // Per-cycle comparison of DUT activity against the model queues
    task automatic compare_loop();
        logic       pv, pb, pg, pe;
        logic [7:0] pd;
        wr_t        e;
        logic [7:0] t;
        logic [3:0] f;
        pv = 0; pb = 0; pg = 0; pe = 0; pd = 0;
        forever begin
            @(negedge dest_clk);
            if (!dest_rst) begin
                pv = 0; pb = 0; pg = 0; pe = 0;
                continue;
            end
            if (rf_wr_en || rf_rd_en) chk("wr_rd_exclusive", rf_wr_en & rf_rd_en, 0);
            if (rf_wr_en) begin
                chk("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", rf_addr, e.a);
                    chk("wr_data", rf_wr_data, e.d);
                end
            end
            if (rf_rd_en) begin
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("rd_addr", rf_addr, exp_rd.pop_front());
            end
            if (alu_en) begin
                chk("alu_expected", exp_fun.size() != 0, 1);
                if (exp_fun.size() != 0) begin
                    f = exp_fun.pop_front();
                    chk("alu_fun", alu_fun, f);
                end
                chk("gate_before_alu_en", pg, 1);
                chk("gate_with_alu_en", clk_gate_en, 1);
            end
            if (pv && pb) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, pd);
            end
            if (pv && !pb) chk("tx_gap", tx_valid, 0);
            if (tx_valid && !tx_busy) begin
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) begin
                    t = exp_tx.pop_front();
                    chk("tx_byte", tx_data, t);
                end
            end
            if (frame_err) begin
                err_seen++;
                chk("frame_err_one_cycle", pe, 0);
            end
            pv = tx_valid; pb = tx_busy; pd = tx_data; pg = clk_gate_en; pe = frame_err;
        end
    endtask

    initial begin
        checks = 0; failures = 0; err_exp = 0; err_seen = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        dest_rst = 1'b0; sync_bus = 8'h00; enable_pulse_d = 1'b0; tx_busy = 1'b0;
        spur_rd_valid = 1'b0; spur_alu_valid = 1'b0; alu_resp = 16'h0000; alu_lat = 3;
        #1;
        // reset state
        chk("rst_rf_wr_en", rf_wr_en, 0);
        chk("rst_rf_rd_en", rf_rd_en, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wr_data", rf_wr_data, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_fun", alu_fun, 0);
        chk("rst_gate", clk_gate_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_frame_err", frame_err, 0);
        cycles(2);
        dest_rst = 1'b1;
        cycles(1);
        fork
            compare_loop();
        join_none

        // write then read back address 5
        exp_wr.push_back('{a: 4'h5, d: 8'h3C}); model_mem[5] = 8'h3C;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        chk("wr_strobe_now", rf_wr_en, 1);
        chk("wr_addr_lit", rf_addr, 4'h5);
        chk("wr_data_lit", rf_wr_data, 8'h3C);
        cycles(1);
        chk("wr_strobe_single", rf_wr_en, 0);
        push_rd(4'h5);
        send_byte(8'hBB); send_byte(8'h05);
        wait_tx_valid(20);
        chk("rd_tx_lit", tx_data, 8'h3C);
        wait_done(50);
        chk("rd_one_byte", tx_valid, 0);

        // ALU with operands
        alu_resp = 16'h0046;
        exp_wr.push_back('{a: 4'h0, d: 8'h12}); model_mem[0] = 8'h12;
        exp_wr.push_back('{a: 4'h1, d: 8'h34}); model_mem[1] = 8'h34;
        push_alu(4'h0, 16'h0046);
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
        chk("opb_addr_lit", rf_addr, 4'h1);
        chk("gate_in_get_fun", clk_gate_en, 1);
        chk("no_alu_en_yet", alu_en, 0);
        send_byte(8'h00);
        chk("alu_en_lit", alu_en, 1);
        chk("alu_fun_lit", alu_fun, 4'h0);
        wait_done(60);
        chk("gate_off_after", clk_gate_en, 0);

        // TX backpressure
        alu_resp = 16'hBEEF;
        push_alu(4'h2, 16'hBEEF);
        tx_busy = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        wait_tx_valid(30);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", tx_valid, 1);
            chk("bp_data", tx_data, 8'hEF);
            cycles(1);
        end
        tx_busy = 1'b0;
        wait_done(60);
        chk("alu_fun_holds", alu_fun, 4'h2);

        // illegal command
        send_byte(8'h7F); err_exp++;
        chk("illegal_err_lit", frame_err, 1);
        cycles(1);
        chk("illegal_err_pulse", frame_err, 0);
        cycles(3);

        // overrun byte during WAIT_ALU
        alu_lat = 6;
        alu_resp = 16'hA55A;
        push_alu(4'h3, 16'hA55A);
        send_byte(8'hDD); send_byte(8'h03);
        send_byte(8'h99); err_exp++;
        chk("overrun_err_lit", frame_err, 1);
        wait_done(60);
        alu_lat = 3;

        // spurious handshakes in IDLE
        @(posedge dest_clk); #1;
        spur_rd_valid = 1'b1; spur_alu_valid = 1'b1;
        cycles(1);
        spur_rd_valid = 1'b0; spur_alu_valid = 1'b0;
        cycles(4);
        chk("spur_no_tx", tx_valid, 0);
        chk("spur_no_gate", clk_gate_en, 0);
        push_rd(4'h0);
        send_byte(8'hBB); send_byte(8'h00);
        wait_done(50);

        // reset during SEND_HI
        alu_resp = 16'h1234;
        push_alu(4'h5, 16'h1234);
        tx_busy = 1'b1;
        send_byte(8'hDD); send_byte(8'h05);
        wait_tx_valid(30);
        chk("lo_before_reset", tx_data, 8'h34);
        @(posedge dest_clk); #1; tx_busy = 1'b0;
        @(posedge dest_clk); #1; tx_busy = 1'b1;
        wait_tx_valid(30);
        chk("hi_before_reset", tx_data, 8'h12);
        #2 dest_rst = 1'b0;
        #1;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_alu_fun", alu_fun, 0);
        chk("abort_rf_addr", rf_addr, 0);
        chk("abort_gate", clk_gate_en, 0);
        exp_tx.delete();
        cycles(2);
        tx_busy = 1'b0;
        dest_rst = 1'b1;
        push_rd(4'h1);
        send_byte(8'hBB); send_byte(8'h01);
        wait_tx_valid(20);
        chk("post_reset_read", tx_data, 8'h34);
        wait_done(50);

        chk("frame_err_count", err_seen, err_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_cmd_sequencer.md
Name: rx_cmd_sequencer

Overview:
- Destination-domain controller that consumes synchronized RX bytes (sync_bus qualified by the one-cycle enable_pulse_d from the bus synchronizer).
- Parses them into command frames and sequences the register file and ALU.
- Returns read/ALU results byte-wise over a valid/busy handshake to the TX path.
- Sits between the RX synchronizer and the RF/ALU/TX-sync blocks of the UART-ALU system.

Parameters:
DATA_WIDTH, 8, byte width of sync_bus, RF data and TX data
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
ALU_OUT_WIDTH, 16, ALU result width (must equal 2*DATA_WIDTH)

Ports:
dest_clk  in  1  destination clock; all logic on rising edge
dest_rst  in  1  asynchronous, active-low reset
sync_bus  in  DATA_WIDTH  synchronized RX byte
enable_pulse_d  in  1  one-cycle strobe, sync_bus valid
rf_wr_en  out  1  register-file write strobe
rf_rd_en  out  1  register-file read strobe
rf_addr  out  ADDR_WIDTH  register-file address
rf_wr_data  out  DATA_WIDTH  register-file write data
rf_rd_data  in  DATA_WIDTH  register-file read data
rf_rd_valid  in  1  rf_rd_data valid (single cycle)
alu_en  out  1  ALU start strobe
alu_fun  out  FUN_WIDTH  ALU function code
alu_out  in  ALU_OUT_WIDTH  ALU result
alu_out_valid  in  1  alu_out valid (single cycle)
clk_gate_en  out  1  ALU clock-gate enable
tx_data  out  DATA_WIDTH  response byte
tx_valid  out  1  tx_data valid
tx_busy  in  1  TX path cannot accept
frame_err  out  1  one-cycle error pulse

Behaviour:
- Reset (dest_rst=0, async): state IDLE; all outputs 0, including rf_addr, rf_wr_data, alu_fun, tx_data and internal result/address registers.
- A byte is consumed only on a cycle with enable_pulse_d=1, and only in IDLE or a GET_* state.
- Commands (first byte, decoded in IDLE):
  - 0xAA: RF write; frame = addr, data.
  - 0xBB: RF read; frame = addr.
  - 0xCC: ALU with operands; frame = opA, opB, fun.
  - 0xDD: ALU, no operands; frame = fun.
  - Any other value: frame_err pulse next cycle, remain IDLE.
- Addresses take the low ADDR_WIDTH bits of the byte; fun takes the low FUN_WIDTH bits.
- States: IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN, RF_RD, WAIT_RD, ALU_ISSUE, WAIT_ALU, SEND_LO, SEND_HI.
- RF write (0xAA):
  - GET_ADDR latches addr.
  - The GET_WDATA byte drives rf_wr_en=1, rf_addr, rf_wr_data for exactly one cycle, the cycle after the pulse.
  - Then IDLE.
- Operand writes (0xCC): opA is written to address 0 and opB to address 1, each as a one-cycle rf_wr_en in the cycle after its pulse.
- RF read (0xBB):
  - After the addr byte: RF_RD asserts rf_rd_en=1 with rf_addr for one cycle.
  - WAIT_RD until rf_rd_valid=1; capture rf_rd_data.
  - SEND_LO sends the captured byte, then IDLE. No SEND_HI.
- ALU (0xCC/0xDD):
  - The fun byte latches alu_fun, then ALU_ISSUE: alu_en=1 for one cycle.
  - WAIT_ALU until alu_out_valid; capture alu_out.
  - SEND_LO sends alu_out[7:0], SEND_HI sends alu_out[15:8], then IDLE.
  - alu_fun holds its value until the next fun byte.
- clk_gate_en=1 exactly while state is GET_FUN, ALU_ISSUE or WAIT_ALU; it is asserted a cycle before alu_en.
- TX handshake:
  - In SEND_*, tx_valid=1 and tx_data stays stable until a rising edge with tx_valid=1 and tx_busy=0. That edge is the transfer.
  - tx_valid is 0 for at least 1 cycle between SEND_LO and SEND_HI and after SEND_HI.
  - tx_busy held high stalls indefinitely with no data change.
- Overrun: enable_pulse_d while in RF_RD, WAIT_RD, ALU_ISSUE, WAIT_ALU or SEND_* drops the byte, asserts frame_err for one cycle, and leaves the sequence unaffected.
- rf_rd_valid or alu_out_valid outside the matching WAIT state is ignored.
- Simultaneous rf_wr_en and rf_rd_en never occur.
- Reset mid-frame or mid-send aborts immediately: tx_valid drops, and the next byte after release is decoded as a command.

Test Plan:
- Write/readback: pulses 0xAA,0x5,0x3C then 0xBB,0x5, RF model returns 0x3C → rf_wr_en one cycle with addr 5/data 0x3C; later rf_rd_en addr 5; tx_data=0x3C with tx_valid; one byte only.
- ALU with operands: 0xCC,0x12,0x34,0x0 with ALU returning 0x0046 → writes 0x12@0 and 0x34@1; clk_gate_en high one cycle before alu_en; alu_fun=0; TX bytes 0x46 then 0x00 with a tx_valid gap.
- TX backpressure: 0xDD,0x2 with alu_out=0xBEEF and tx_busy high 20 cycles → tx_valid=1, tx_data=0xEF stable throughout; 0xBE sent only after 0xEF accepted.
- Illegal/overrun: pulse 0x7F in IDLE → frame_err one cycle, no RF/ALU activity; extra pulse during WAIT_ALU → frame_err, result still sent correctly.
- Reset mid-operation: dest_rst low during SEND_HI, then 0xBB,0x1 → all outputs 0 immediately; clean read of address 1 follows.
- Spurious handshakes: rf_rd_valid/alu_out_valid pulses in IDLE → no state change, no tx_valid.
